// File: rtl/riscv_fetch_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// An entry bundles the fetched pc, the instruction word and the access-fault flag.
package riscv_fetch_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            fault;
  } fq_entry_t;

  localparam int ENTRY_W = $bits(fq_entry_t);

  // Value presented to decode whenever the queue holds nothing.
  function automatic fq_entry_t empty_entry();
    fq_entry_t e;
    e.pc    = '0;
    e.instr = NOP_INSTR;
    e.fault = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/riscv_fetch_queue_mem.sv
// Entry storage for the fetch queue: one write port, one asynchronous read port.
// The array has no reset; stale contents are masked by the queue's empty flag.
module riscv_fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/riscv_fetch_queue.sv
// Instruction queue between fetch and decode; a flush empties it in one cycle.
// Ready/valid come only from registered pointers, so fetch ready never depends on decode stall.
module riscv_fetch_queue
  import riscv_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [XLEN-1:0]  i_push_pc,
  input  logic [31:0]      i_push_instr,
  input  logic             i_push_fault,
  output logic             o_pop_valid,
  input  logic             i_pop_ready,
  output logic [XLEN-1:0]  o_pop_pc,
  output logic [31:0]      o_pop_instr,
  output logic             o_pop_fault,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [CNT_W-2:0] wr_idx;
  logic [CNT_W-2:0] rd_idx;
  logic             empty;
  logic             full;
  logic             push_fire;
  logic             pop_fire;
  fq_entry_t        wr_entry;
  fq_entry_t        rd_entry;
  fq_entry_t        head;

  assign wr_idx = wr_ptr[CNT_W-2:0];
  assign rd_idx = rd_ptr[CNT_W-2:0];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]) && (wr_idx == rd_idx);

  assign push_fire = i_push_valid && !full && !i_clr;
  assign pop_fire  = !empty && i_pop_ready && !i_clr;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign wr_entry.pc    = i_push_pc;
  assign wr_entry.instr = i_push_instr;
  assign wr_entry.fault = i_push_fault;

  riscv_fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push_fire),
    .i_waddr (wr_idx),
    .i_wdata (wr_entry),
    .i_raddr (rd_idx),
    .o_rdata (rd_entry)
  );

  always_comb begin
    head = rd_entry;
    if (empty) begin
      head = empty_entry();
    end
  end

  assign o_push_ready = !full;
  assign o_pop_valid  = !empty;
  assign o_pop_pc     = head.pc;
  assign o_pop_instr  = head.instr;
  assign o_pop_fault  = head.fault;
  assign o_count      = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed self-checking bench for riscv_fetch_queue (DEPTH=4).
module tb_riscv_fetch_queue;
  import riscv_fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             push_valid;
  logic             push_ready;
  logic [XLEN-1:0]  push_pc;
  logic [31:0]      push_instr;
  logic             push_fault;
  logic             pop_valid;
  logic             pop_ready;
  logic [XLEN-1:0]  pop_pc;
  logic [31:0]      pop_instr;
  logic             pop_fault;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int fails  = 0;

  riscv_fetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clr        (clr),
    .i_push_valid (push_valid),
    .o_push_ready (push_ready),
    .i_push_pc    (push_pc),
    .i_push_instr (push_instr),
    .i_push_fault (push_fault),
    .o_pop_valid  (pop_valid),
    .i_pop_ready  (pop_ready),
    .o_pop_pc     (pop_pc),
    .o_pop_instr  (pop_instr),
    .o_pop_fault  (pop_fault),
    .o_count      (count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic v, input logic [XLEN-1:0] pc,
                            input logic [31:0] instr, input logic fault);
    push_valid = v;
    push_pc    = pc;
    push_instr = instr;
    push_fault = fault;
  endtask

  function automatic logic [31:0] instr_of(input logic [XLEN-1:0] pc);
    return {16'hA5A5, pc[15:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    clr = 1'b0;
    pop_ready = 1'b0;
    drive_push(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    checks++; if (count !== 3'd0) begin fails++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    checks++; if (pop_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_pop_valid got %b want 0", pop_valid); end
    checks++; if (push_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_push_ready got %b want 1", push_ready); end
    checks++; if (pop_instr !== 32'h13) begin fails++; $display("[TB] FAIL reset_pop_instr got %h want 00000013", pop_instr); end
    checks++; if (pop_pc !== '0 || pop_fault !== 1'b0) begin fails++; $display("[TB] FAIL reset_pop_pc_fault got %h/%b want 0/0", pop_pc, pop_fault); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    logic [XLEN-1:0] exp_pc;
    pop_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'h100 + 32'(4 * i);
      drive_push(1'b1, exp_pc, instr_of(exp_pc), 1'b0);
      tick();
      checks++; if (count !== 3'(i + 1)) begin fails++; $display("[TB] FAIL fill_count got %0d want %0d", count, i + 1); end
    end
    checks++; if (push_ready !== 1'b0) begin fails++; $display("[TB] FAIL full_push_ready got %b want 0", push_ready); end
    // Fifth entry offered while full must be held off.
    drive_push(1'b1, 32'h110, instr_of(32'h110), 1'b0);
    tick();
    checks++; if (count !== 3'd4) begin fails++; $display("[TB] FAIL full_hold_count got %0d want 4", count); end
    pop_ready = 1'b1;
    #1;
    checks++; if (push_ready !== 1'b0) begin fails++; $display("[TB] FAIL full_no_ready_through_pop got %b want 0", push_ready); end
    checks++; if (pop_pc !== 32'h100 || pop_instr !== instr_of(32'h100)) begin fails++; $display("[TB] FAIL drain_head0 got %h/%h want 00000100", pop_pc, pop_instr); end
    tick();
    checks++; if (count !== 3'd3) begin fails++; $display("[TB] FAIL first_pop_count got %0d want 3", count); end
    checks++; if (pop_pc !== 32'h104) begin fails++; $display("[TB] FAIL drain_head1 got %h want 00000104", pop_pc); end
    tick();
    checks++; if (count !== 3'd3) begin fails++; $display("[TB] FAIL fifth_push_count got %0d want 3", count); end
    drive_push(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h108 + 32'(4 * i);
      checks++; if (pop_pc !== exp_pc || pop_valid !== 1'b1) begin fails++; $display("[TB] FAIL drain_order got %h valid %b want %h", pop_pc, pop_valid, exp_pc); end
      tick();
      checks++; if (count !== 3'(2 - i)) begin fails++; $display("[TB] FAIL drain_count got %0d want %0d", count, 2 - i); end
    end
    checks++; if (pop_valid !== 1'b0 || pop_instr !== 32'h13) begin fails++; $display("[TB] FAIL drained_empty got %b/%h want 0/00000013", pop_valid, pop_instr); end
    // Pop request on an empty queue has no effect.
    tick();
    checks++; if (count !== 3'd0) begin fails++; $display("[TB] FAIL empty_pop_count got %0d want 0", count); end
    pop_ready = 1'b0;
  endtask

  task automatic test_concurrent();
    logic [XLEN-1:0] exp_pc;
    pop_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_push(1'b1, 32'h300 + 32'(4 * i), instr_of(32'h300 + 32'(4 * i)), 1'b0);
      tick();
    end
    checks++; if (count !== 3'd2) begin fails++; $display("[TB] FAIL conc_prefill got %0d want 2", count); end
    pop_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_pc = 32'h300 + 32'(4 * k);
      drive_push(1'b1, 32'h308 + 32'(4 * k), instr_of(32'h308 + 32'(4 * k)), 1'b0);
      #1;
      checks++; if (pop_pc !== exp_pc || pop_instr !== instr_of(exp_pc)) begin fails++; $display("[TB] FAIL conc_order got %h want %h", pop_pc, exp_pc); end
      tick();
      checks++; if (count !== 3'd2) begin fails++; $display("[TB] FAIL conc_count got %0d want 2", count); end
    end
    drive_push(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_pc = 32'h328 + 32'(4 * i);
      checks++; if (pop_pc !== exp_pc) begin fails++; $display("[TB] FAIL conc_tail got %h want %h", pop_pc, exp_pc); end
      tick();
    end
    checks++; if (count !== 3'd0 || pop_valid !== 1'b0) begin fails++; $display("[TB] FAIL conc_end got %0d/%b want 0/0", count, pop_valid); end
    pop_ready = 1'b0;
  endtask

  task automatic test_flush();
    pop_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(1'b1, 32'h400 + 32'(4 * i), instr_of(32'h400 + 32'(4 * i)), 1'b1);
      tick();
    end
    checks++; if (count !== 3'd3) begin fails++; $display("[TB] FAIL flush_prefill got %0d want 3", count); end
    clr = 1'b1;
    pop_ready = 1'b1;
    drive_push(1'b1, 32'h40C, instr_of(32'h40C), 1'b0);
    tick();
    clr = 1'b0;
    pop_ready = 1'b0;
    drive_push(1'b0, '0, '0, 1'b0);
    checks++; if (count !== 3'd0 || pop_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_empty got %0d/%b want 0/0", count, pop_valid); end
    checks++; if (pop_pc !== '0 || pop_instr !== 32'h13 || pop_fault !== 1'b0) begin fails++; $display("[TB] FAIL flush_masked got %h/%h/%b want 0/00000013/0", pop_pc, pop_instr, pop_fault); end
    drive_push(1'b1, 32'h200, instr_of(32'h200), 1'b0);
    tick();
    drive_push(1'b0, '0, '0, 1'b0);
    checks++; if (pop_valid !== 1'b1 || pop_pc !== 32'h200 || count !== 3'd1) begin fails++; $display("[TB] FAIL flush_next_head got %b/%h/%0d want 1/00000200/1", pop_valid, pop_pc, count); end
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
    // A flush on an empty queue leaves it empty and ready.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (count !== 3'd0 || push_ready !== 1'b1) begin fails++; $display("[TB] FAIL flush_idle got %0d/%b want 0/1", count, push_ready); end
  endtask

  task automatic test_fault_carry();
    pop_ready = 1'b0;
    drive_push(1'b1, 32'h500, 32'h0000_0073, 1'b1);
    tick();
    drive_push(1'b1, 32'h504, 32'h0000_0013, 1'b0);
    tick();
    drive_push(1'b0, '0, '0, 1'b0);
    checks++; if (pop_fault !== 1'b1 || pop_pc !== 32'h500 || pop_instr !== 32'h73) begin fails++; $display("[TB] FAIL fault_head got %b/%h/%h want 1/00000500/00000073", pop_fault, pop_pc, pop_instr); end
    pop_ready = 1'b1;
    tick();
    checks++; if (pop_fault !== 1'b0 || pop_pc !== 32'h504) begin fails++; $display("[TB] FAIL fault_next got %b/%h want 0/00000504", pop_fault, pop_pc); end
    tick();
    pop_ready = 1'b0;
    checks++; if (pop_valid !== 1'b0 || pop_fault !== 1'b0) begin fails++; $display("[TB] FAIL fault_empty got %b/%b want 0/0", pop_valid, pop_fault); end
  endtask

  task automatic test_reset_mid();
    pop_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(1'b1, 32'h600 + 32'(4 * i), instr_of(32'h600 + 32'(4 * i)), 1'b1);
      tick();
    end
    checks++; if (count !== 3'd3) begin fails++; $display("[TB] FAIL rstmid_prefill got %0d want 3", count); end
    clr = 1'b1;
    rst = 1'b1;
    drive_push(1'b1, 32'h60C, instr_of(32'h60C), 1'b0);
    tick();
    rst = 1'b0;
    clr = 1'b0;
    drive_push(1'b0, '0, '0, 1'b0);
    checks++; if (count !== 3'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_flags got %0d/%b/%b want 0/0/1", count, pop_valid, push_ready); end
    checks++; if (pop_pc !== '0 || pop_instr !== 32'h13 || pop_fault !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_outputs got %h/%h/%b want 0/00000013/0", pop_pc, pop_instr, pop_fault); end
    drive_push(1'b1, 32'h700, instr_of(32'h700), 1'b0);
    tick();
    drive_push(1'b0, '0, '0, 1'b0);
    checks++; if (count !== 3'd1 || pop_pc !== 32'h700) begin fails++; $display("[TB] FAIL rstmid_recover got %0d/%h want 1/00000700", count, pop_pc); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_concurrent();
    test_flush();
    test_fault_carry();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
